// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner.
// Scan/swap FSM encodings and the column-enable one-hot builder.
package led_matrix_pkg;

  typedef enum logic {
    SCAN_BLANK,
    SCAN_DRIVE
  } scan_state_t;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  localparam int MAX_EN = 1024;

  // Callers truncate the result to CHANNELS*COLS bits.
  function automatic logic [MAX_EN-1:0] col_onehot(
    input int c,
    input int ch,
    input int cols
  );
    return {{(MAX_EN-1){1'b0}}, 1'b1} << (ch * cols + c);
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Column write port and buffer-swap handshake of the LED scanner.
// The master drives writes and swap requests; the scanner is the slave.
interface led_matrix_scan_if #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CHANNELS = 2
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                     wr_valid;
  logic                     wr_ready;
  logic [CW-1:0]            wr_col;
  logic [CHANNELS*ROWS-1:0] wr_data;
  logic                     swap_req;
  logic                     swap_done;

  modport master (
    output wr_valid, wr_col, wr_data, swap_req,
    input  wr_ready, swap_done
  );

  modport slave (
    input  wr_valid, wr_col, wr_data, swap_req,
    output wr_ready, swap_done
  );

endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered frame storage: writes go to the back buffer,
// a registered read port serves the front buffer by (col, ch).
module led_frame_buffer #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CHANNELS = 2,
  parameter int CW       = 3,
  parameter int HW       = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [CW-1:0]            i_wr_col,
  input  logic [CHANNELS*ROWS-1:0] i_wr_data,
  input  logic [CW-1:0]            i_rd_col,
  input  logic [HW-1:0]            i_rd_ch,
  input  logic                     i_toggle,
  output logic [ROWS-1:0]          o_rd_data
);

  logic [CHANNELS*ROWS-1:0] r_mem [2][COLS];
  logic                     r_front;
  logic [ROWS-1:0]          r_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COLS; c++)
          r_mem[b][c] <= '1;
      r_front <= 1'b0;
      r_rd    <= '1;
    end else begin
      // Write lands in the old back buffer even on a toggle cycle.
      if (i_wr_en && (32'(i_wr_col) < COLS))
        r_mem[~r_front][i_wr_col] <= i_wr_data;
      r_front <= r_front ^ i_toggle;
      r_rd    <= r_mem[r_front][i_rd_col][i_rd_ch*ROWS +: ROWS];
    end
  end

  assign o_rd_data = r_rd;

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered ROWSxCOLS LED matrix scanner with per-slot blanking
// and tear-free buffer swaps on frame boundaries.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int CHANNELS     = 2,
  parameter int SCAN_DIV     = 16384,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  led_matrix_scan_if.slave         bus,
  output logic                     frame_tick,
  output logic [ROWS-1:0]          row,
  output logic [CHANNELS*COLS-1:0] col
);

  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int HW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int EN_W = CHANNELS * COLS;

  logic [DW-1:0] r_dwell;
  logic [HW-1:0] r_ch;
  logic [CW-1:0] r_col;

  scan_state_t r_scan, w_scan_nxt;
  swap_state_t r_swap, w_swap_nxt;

  logic            w_dwell_wrap;
  logic            w_ch_wrap;
  logic            w_col_last;
  logic            w_boundary;
  logic            w_toggle;
  logic            w_wr_en;
  logic [ROWS-1:0] w_rd_data;

  logic            r_drive;
  logic [EN_W-1:0] r_col_en;
  logic            r_frame_tick;
  logic            r_swap_done;

  assign w_dwell_wrap = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_ch_wrap    = (r_ch == HW'(CHANNELS - 1));
  assign w_col_last   = (r_col == CW'(COLS - 1));
  assign w_boundary   = w_dwell_wrap && w_ch_wrap && w_col_last;
  assign w_wr_en      = bus.wr_valid && (r_swap == SWAP_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell <= '0;
      r_ch    <= '0;
      r_col   <= '0;
    end else if (w_dwell_wrap) begin
      r_dwell <= '0;
      if (w_ch_wrap) begin
        r_ch  <= '0;
        r_col <= w_col_last ? '0 : r_col + 1'b1;
      end else begin
        r_ch  <= r_ch + 1'b1;
      end
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan <= SCAN_BLANK;
      r_swap <= SWAP_IDLE;
    end else begin
      r_scan <= w_scan_nxt;
      r_swap <= w_swap_nxt;
    end
  end

  always_comb begin
    w_scan_nxt = r_scan;
    unique case (r_scan)
      SCAN_BLANK:
        if (r_dwell == DW'(BLANK_CYCLES - 1))
          w_scan_nxt = SCAN_DRIVE;
      SCAN_DRIVE:
        if (w_dwell_wrap)
          w_scan_nxt = SCAN_BLANK;
      default: w_scan_nxt = SCAN_BLANK;
    endcase
  end

  // A request arriving while pending (or on the swapping boundary) merges.
  always_comb begin
    w_swap_nxt = r_swap;
    w_toggle   = 1'b0;
    unique case (r_swap)
      SWAP_IDLE:
        if (bus.swap_req)
          w_swap_nxt = SWAP_PENDING;
      SWAP_PENDING:
        if (w_boundary) begin
          w_swap_nxt = SWAP_IDLE;
          w_toggle   = 1'b1;
        end
      default: w_swap_nxt = SWAP_IDLE;
    endcase
  end

  led_frame_buffer #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .CHANNELS (CHANNELS),
    .CW       (CW),
    .HW       (HW)
  ) u_fb (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_col  (bus.wr_col),
    .i_wr_data (bus.wr_data),
    .i_rd_col  (r_col),
    .i_rd_ch   (r_ch),
    .i_toggle  (w_toggle),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drive      <= 1'b0;
      r_col_en     <= '0;
      r_frame_tick <= 1'b0;
      r_swap_done  <= 1'b0;
    end else begin
      r_drive      <= (r_scan == SCAN_DRIVE);
      r_col_en     <= (r_scan == SCAN_DRIVE)
                    ? EN_W'(col_onehot(int'(r_col), int'(r_ch), COLS))
                    : '0;
      r_frame_tick <= w_boundary;
      r_swap_done  <= w_toggle;
    end
  end

  assign row           = r_drive ? w_rd_data : '1;
  assign col           = r_col_en;
  assign frame_tick    = r_frame_tick;
  assign bus.swap_done = r_swap_done;
  assign bus.wr_ready  = (r_swap == SWAP_IDLE);

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan against a frame-level model.
module tb_led_matrix_scan;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CH    = 2;
  localparam int SD    = 16;
  localparam int BL    = 2;
  localparam int FRAME = COLS * CH * SD;
  localparam int COLS7 = 7;
  localparam int FRM7  = COLS7 * CH * SD;

  typedef struct packed {
    logic [ROWS-1:0]    row;
    logic [CH*COLS-1:0] col;
    logic               tick;
    logic               done;
    logic               rdy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic rst7;
  logic               frame_tick, frame_tick7;
  logic [ROWS-1:0]    row, row7;
  logic [CH*COLS-1:0] col;
  logic [CH*COLS7-1:0] col7;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  led_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS), .CHANNELS(CH)) bus ();
  led_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS7), .CHANNELS(CH)) bus7 ();

  led_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .CHANNELS(CH),
    .SCAN_DIV(SD), .BLANK_CYCLES(BL)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .frame_tick(frame_tick), .row(row), .col(col)
  );

  led_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS7), .CHANNELS(CH),
    .SCAN_DIV(SD), .BLANK_CYCLES(BL)
  ) u_dut7 (
    .clk(clk), .reset(rst7), .bus(bus7),
    .frame_tick(frame_tick7), .row(row7), .col(col7)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: frame position, two buffers, pending flag.
  logic [ROWS-1:0] m_buf [2][COLS][CH];
  bit   m_fsel;
  bit   m_pend;
  bit   started = 0;
  int   m_pos;
  exp_t exp_q[$];

  always @(posedge clk) begin
    exp_t e;
    int   dwell, slot, c, ch;
    bit   bnd, pend_n;
    if (reset) begin
      started = 1;
      m_pos   = 0;
      m_pend  = 0;
      m_fsel  = 0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < COLS; i++)
          for (int k = 0; k < CH; k++)
            m_buf[b][i][k] = '1;
      e = '{row: '1, col: '0, tick: 1'b0, done: 1'b0, rdy: 1'b1};
      exp_q.push_back(e);
    end else if (started) begin
      dwell  = m_pos % SD;
      slot   = m_pos / SD;
      c      = slot / CH;
      ch     = slot % CH;
      bnd    = (m_pos == FRAME - 1);
      e.row  = (dwell < BL) ? '1 : m_buf[m_fsel][c][ch];
      e.col  = (dwell < BL) ? '0 : (CH*COLS)'(1) << (ch * COLS + c);
      e.tick = bnd;
      e.done = bnd && m_pend;
      pend_n = m_pend ? !bnd : bus.swap_req;
      e.rdy  = !pend_n;
      if (bus.wr_valid && !m_pend && int'(bus.wr_col) < COLS)
        for (int k = 0; k < CH; k++)
          m_buf[!m_fsel][bus.wr_col][k] = bus.wr_data[k*ROWS +: ROWS];
      if (bnd && m_pend)
        m_fsel = !m_fsel;
      m_pend = pend_n;
      m_pos  = (m_pos + 1) % FRAME;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("row",        32'(row),           32'(e.row));
      chk("col",        32'(col),           32'(e.col));
      chk("frame_tick", 32'(frame_tick),    32'(e.tick));
      chk("swap_done",  32'(bus.swap_done), 32'(e.done));
      chk("wr_ready",   32'(bus.wr_ready),  32'(e.rdy));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int c, input logic [CH*ROWS-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_col   = 3'(c);
    bus.wr_data  = d;
    step(1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic swap_pulse();
    bus.swap_req = 1'b1;
    step(1);
    bus.swap_req = 1'b0;
  endtask

  initial begin
    bit seen;
    int dw, sl, c, ch;
    logic [ROWS-1:0] er;
    reset         = 1'b1;
    rst7          = 1'b1;
    bus.wr_valid  = 1'b0;
    bus.wr_col    = '0;
    bus.wr_data   = '0;
    bus.swap_req  = 1'b0;
    bus7.wr_valid = 1'b0;
    bus7.wr_col   = '0;
    bus7.wr_data  = '0;
    bus7.swap_req = 1'b0;
    step(3);
    reset = 1'b0;
    step(FRAME);

    wr(3, {8'hFF, 8'hA5});
    swap_pulse();
    step(2 * FRAME + 20);

    for (int i = 0; i < 3000; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_col   = 3'($urandom);
      bus.wr_data  = 16'($urandom);
      bus.swap_req = ($urandom_range(0, 99) == 0);
      step(1);
    end
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b0;
    step(FRAME + 20);

    // Swap request on the exact boundary cycle, with a same-cycle write.
    while (m_pos != FRAME - 1) step(1);
    bus.wr_valid = 1'b1;
    bus.wr_col   = 3'd0;
    bus.wr_data  = 16'h5A3C;
    bus.swap_req = 1'b1;
    step(1);
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b0;
    step(2 * FRAME + 20);

    wr(6, 16'h0F81);
    swap_pulse();
    step(5);
    swap_pulse();
    step(2 * FRAME + 20);

    wr(5, 16'h1234);
    swap_pulse();
    step(50);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(FRAME + 20);

    // COLS=7 build: out-of-range column is accepted and dropped.
    rst7 = 1'b0;
    bus7.wr_valid = 1'b1;
    bus7.wr_col   = 3'd2;
    bus7.wr_data  = {8'hFF, 8'h3C};
    chk("dut7_ready_c2", 32'(bus7.wr_ready), 32'd1);
    step(1);
    bus7.wr_col   = 3'd7;
    bus7.wr_data  = '0;
    chk("dut7_ready_c7", 32'(bus7.wr_ready), 32'd1);
    step(1);
    bus7.wr_valid = 1'b0;
    bus7.swap_req = 1'b1;
    step(1);
    bus7.swap_req = 1'b0;
    seen = 0;
    for (int k = 0; k < FRM7 + 20 && !seen; k++) begin
      step(1);
      if (bus7.swap_done) seen = 1;
    end
    chk("dut7_swap_done", 32'(seen), 32'd1);
    if (seen) begin
      for (int p = 0; p < FRM7; p++) begin
        step(1);
        dw = p % SD;
        sl = p / SD;
        c  = sl / CH;
        ch = sl % CH;
        er = (dw >= BL && c == 2 && ch == 0) ? 8'h3C : 8'hFF;
        chk("dut7_row", 32'(row7), 32'(er));
      end
    end
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
